// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a one-word holding buffer, so a new word can
// be loaded while the current one shifts out; bits advance on each shift_en tick.
module piso_serializer #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              shift_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;

  // Move the next bit toward whichever end drives ser_out, filling with zero.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
    if (LSB_FIRST) return {1'b0, v[DATA_W-1:1]};
    else           return {v[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    accept     = in_valid && !buf_full_q;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = shift_one(shreg_q);
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (buf_full_q) begin
            // Reload straight from the buffer so consecutive words have no gap bit.
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
            cnt_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only when empty, so it can never collide with a transfer out of buf_q.
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = !buf_full_q;
  assign ser_valid = (state_q == SHIFT);
  assign ser_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign ser_out   = (state_q == SHIFT) ? (LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1])
                                        : IDLE_LEVEL;
  assign busy      = (state_q == SHIFT) || buf_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus randomized traffic against a
// queue-based model of the word/bit stream (MSB-first instance and LSB-first/idle-1 one).
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       iv0, se0, rdy0, so0, sv0, sl0, busy0;
  logic [7:0] d0;
  logic       iv1, se1, rdy1, so1, sv1, sl1, busy1;
  logic [7:0] d1;

  int tests;
  int fails;

  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(d0), .in_ready(rdy0),
    .shift_en(se0), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0), .busy(busy0)
  );

  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_data(d1), .in_ready(rdy1),
    .shift_en(se1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of dut0: a holding slot plus the queue of bits still to appear on the line.
  logic m_full;
  logic [7:0] m_buf;
  bit m_cur[$];

  task automatic model_reset();
    m_full = 1'b0;
    m_buf  = 8'h00;
    m_cur.delete();
  endtask

  task automatic model_load();
    for (int b = 7; b >= 0; b--) m_cur.push_back(m_buf[b]);
    m_full = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] d, input logic se);
    logic acc;
    acc = iv && !m_full;
    if (m_cur.size() == 0) begin
      if (m_full) model_load();
    end else if (se) begin
      void'(m_cur.pop_front());
      if (m_cur.size() == 0 && m_full) model_load();
    end
    if (acc) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endtask

  function automatic logic [4:0] model_vec();
    logic v;
    v = (m_cur.size() > 0);
    return {v, v ? logic'(m_cur[0]) : 1'b0, (m_cur.size() == 1), !m_full, v || m_full};
  endfunction

  task automatic tick(input logic iv, input logic [7:0] d, input logic se);
    iv0 = iv; d0 = d; se0 = se;
    @(posedge clk);
    model_step(iv, d, se);
    #1;
  endtask

  task automatic tick1(input logic iv, input logic [7:0] d, input logic se);
    iv1 = iv; d1 = d; se1 = se;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    tick(1'b1, 8'h96, 1'b1);
    tick1(1'b1, 8'h69, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    exp = 5'b00010;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL reset_async_dut0: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    exp = 5'b01010;
    tests++;
    if ({sv1, so1, sl1, rdy1, busy1} !== exp) begin
      fails++;
      $display("FAIL reset_async_dut1: got %b expected %b", {sv1, so1, sl1, rdy1, busy1}, exp);
    end
    iv0 = 1'b1; d0 = 8'hFF; se0 = 1'b1;
    @(posedge clk);
    #1;
    exp = 5'b00010;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL reset_hold_dut0: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    iv0 = 1'b0; iv1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'hA5;
    tick(1'b1, w, 1'b1);
    exp = 5'b00001;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL t2_accept: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      exp = (i <= 8) ? {1'b1, w[8-i], (i == 8), 1'b1, 1'b1} : 5'b00010;
      tests++;
      if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
        fails++;
        $display("FAIL t2_bit%0d: got %b expected %b", i, {sv0, so0, sl0, rdy0, busy0}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [4:0] exp;
    w = 16'hA53C;
    tick(1'b1, 8'hA5, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      tick(i == 3, 8'h3C, 1'b1);
      exp = (i <= 16) ? {1'b1, w[16-i], (i == 8 || i == 16), (i < 3 || i >= 9), 1'b1}
                      : 5'b00010;
      tests++;
      if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
        fails++;
        $display("FAIL t3_bit%0d: got %b expected %b", i, {sv0, so0, sl0, rdy0, busy0}, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] w;
    logic [4:0] exp;
    int bitidx;
    int nvalid;
    w = 8'hC3;
    tick(1'b1, w, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    bitidx = 1;
    nvalid = sv0 ? 1 : 0;
    for (int c = 1; c <= 32; c++) begin
      tick(1'b0, 8'h00, (c % 4) == 0);
      if ((c % 4) == 0) bitidx++;
      if (sv0) nvalid++;
      exp = (bitidx <= 8) ? {1'b1, w[8-bitidx], (bitidx == 8), 1'b1, 1'b1} : 5'b00010;
      tests++;
      if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
        fails++;
        $display("FAIL t4_cycle%0d: got %b expected %b", c, {sv0, so0, sl0, rdy0, busy0}, exp);
      end
    end
    tests++;
    if (nvalid !== 32) begin
      fails++;
      $display("FAIL t4_valid_cycles: got %0d expected %0d", nvalid, 32);
    end
  endtask

  task automatic test_lsb_first_idle_high();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'h1E;
    tick1(1'b1, w, 1'b1);
    exp = 5'b01001;
    tests++;
    if ({sv1, so1, sl1, rdy1, busy1} !== exp) begin
      fails++;
      $display("FAIL t5_accept: got %b expected %b", {sv1, so1, sl1, rdy1, busy1}, exp);
    end
    for (int i = 1; i <= 9; i++) begin
      tick1(1'b0, 8'h00, 1'b1);
      exp = (i <= 8) ? {1'b1, w[i-1], (i == 8), 1'b1, 1'b1} : 5'b01010;
      tests++;
      if ({sv1, so1, sl1, rdy1, busy1} !== exp) begin
        fails++;
        $display("FAIL t5_bit%0d: got %b expected %b", i, {sv1, so1, sl1, rdy1, busy1}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [4:0] exp;
    tick(1'b1, 8'hF0, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h55, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    exp = 5'b11001;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL t6_bit3_buffered: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    exp = 5'b00010;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL t6_reset: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    w = 8'h81;
    tick(1'b1, w, 1'b1);
    exp = 5'b00001;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
      fails++;
      $display("FAIL t6_reload_accept: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, exp);
    end
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      exp = (i <= 8) ? {1'b1, w[8-i], (i == 8), 1'b1, 1'b1} : 5'b00010;
      tests++;
      if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
        fails++;
        $display("FAIL t6_bit%0d: got %b expected %b", i, {sv0, so0, sl0, rdy0, busy0}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] exp;
    logic       iv, se;
    logic [7:0] d;
    for (int n = 0; n < 800; n++) begin
      iv = ($urandom % 2) == 0;
      d  = 8'($urandom);
      se = ($urandom % 4) != 0;
      tick(iv, d, se);
      exp = model_vec();
      tests++;
      if ({sv0, so0, sl0, rdy0, busy0} !== exp) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %b expected %b", n, {sv0, so0, sl0, rdy0, busy0}, exp);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    iv0 = 1'b0; d0 = 8'h00; se0 = 1'b0;
    iv1 = 1'b0; d1 = 8'h00; se1 = 1'b0;
    model_reset();
    #2;
    tests++;
    if ({sv0, so0, sl0, rdy0, busy0} !== 5'b00010) begin
      fails++;
      $display("FAIL powerup_reset: got %b expected %b", {sv0, so0, sl0, rdy0, busy0}, 5'b00010);
    end
    #10;
    rst = 1'b0;
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_lsb_first_idle_high();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
